// File: rtl/spi_wb_pkg.sv
// Shared definitions for the SPI-to-Wishbone sequencer.
// Provides the frame sequencer state encoding and the fixed reply byte codes
// returned to the SPI master.
package spi_wb_pkg;

  typedef enum logic [2:0] {
    CMD,
    ADR,
    WDATA,
    REQ,
    WAIT,
    REPLY,
    DONE
  } state_t;

  localparam logic [7:0] STALL_BYTE = 8'h00;
  localparam logic [7:0] ACK_BYTE   = 8'hFF;
  localparam logic [7:0] ERR_BYTE   = 8'hEE;

endpackage

// File: rtl/spi_wb_shreg.sv
// 32-bit byte-wide shift register, MSB first.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears q)
//   load        parallel load of load_data (wins over shift)
//   load_data   32-bit parallel value
//   shift       shift q left by one byte, inserting shift_in at the bottom
//   shift_in    byte inserted on shift
//   q           register contents; q[31:24] is the next byte out
module spi_wb_shreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift,
  input  logic [7:0]  shift_in,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[23:0], shift_in};
    end
  end

endmodule

// File: rtl/spi_wb_sequencer.sv
// Frame sequencer turning received SPI bytes into one Wishbone B4 pipelined
// cycle per frame, answering every received byte with exactly one reply byte.
// Frame: W000SSSS, ADR, then four DAT bytes (MSB first) for writes.
// Reply stream: 0x00 while busy, then 0xFF (ack) or 0xEE (timeout), then
// four read data bytes MSB first for reads.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_start               new frame (CSN fell); aborts whatever is running
//   rx_stb, rx_data        received byte strobe and value
//   tx_stb, tx_data        reply byte strobe (one clk after rx_stb) and value
//   wb_cyc .. wb_dat_o     Wishbone master outputs
//   wb_dat_i, wb_stall,
//   wb_ack                 Wishbone slave responses
module spi_wb_sequencer
  import spi_wb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_start,
  input  logic        rx_stb,
  input  logic [7:0]  rx_data,
  output logic        tx_stb,
  output logic [7:0]  tx_data,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [7:0]  wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_stall,
  input  logic        wb_ack
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t        state, state_d, cur;
  logic [2:0]    cnt, cnt_d;
  logic [TW-1:0] tmo, tmo_d;
  logic          status_err, status_d;
  logic          latch_cmd, latch_adr, wr_shift;
  logic          rd_load, rd_shift;
  logic [31:0]   rd_load_val, rd_q;
  logic [7:0]    tx_data_d;
  logic          unused_rd;

  assign unused_rd = ^rd_q[23:0];

  // Bus handshake is decoded straight from the state register, so an abort
  // or completion drops cyc/stb on the same edge that leaves REQ/WAIT.
  assign wb_cyc = (state == REQ) || (state == WAIT);
  assign wb_stb = (state == REQ);

  spi_wb_shreg u_wr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data (32'h0),
    .shift     (wr_shift),
    .shift_in  (rx_data),
    .q         (wb_dat_o)
  );

  spi_wb_shreg u_rd (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rd_load),
    .load_data (rd_load_val),
    .shift     (rd_shift),
    .shift_in  (8'h00),
    .q         (rd_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CMD;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    tmo_d       = '0;
    status_d    = status_err;
    latch_cmd   = 1'b0;
    latch_adr   = 1'b0;
    wr_shift    = 1'b0;
    rd_load     = 1'b0;
    rd_load_val = '0;
    rd_shift    = 1'b0;
    tx_data_d   = STALL_BYTE;
    // rx_start restarts the frame; a byte arriving with it is the new CMD.
    cur         = rx_start ? CMD : state;
    if (rx_start) state_d = CMD;

    unique case (cur)
      CMD: begin
        if (rx_stb) begin
          latch_cmd = 1'b1;
          state_d   = ADR;
        end
      end
      ADR: begin
        if (rx_stb) begin
          latch_adr = 1'b1;
          cnt_d     = '0;
          state_d   = wb_we ? WDATA : REQ;
        end
      end
      WDATA: begin
        if (rx_stb) begin
          wr_shift = 1'b1;
          cnt_d    = cnt + 3'd1;
          if (cnt == 3'd3) state_d = REQ;
        end
      end
      REQ, WAIT: begin
        tmo_d = tmo + 1'b1;
        if (cur == REQ && !wb_stall) state_d = WAIT;
        // An ack with stb accepted in the same clk completes without WAIT.
        if (wb_ack && (cur == WAIT || !wb_stall)) begin
          rd_load     = 1'b1;
          rd_load_val = wb_dat_i;
          status_d    = 1'b0;
          cnt_d       = '0;
          state_d     = REPLY;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          rd_load     = 1'b1;
          rd_load_val = '0;
          status_d    = 1'b1;
          cnt_d       = '0;
          state_d     = REPLY;
        end
      end
      REPLY: begin
        if (rx_stb) begin
          if (cnt == 3'd0) begin
            tx_data_d = status_err ? ERR_BYTE : ACK_BYTE;
            if (wb_we) state_d = DONE;
            else       cnt_d   = 3'd1;
          end else begin
            tx_data_d = rd_q[31:24];
            rd_shift  = 1'b1;
            cnt_d     = cnt + 3'd1;
            if (cnt == 3'd4) state_d = DONE;
          end
        end
      end
      DONE: begin
      end
      default: state_d = CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we      <= 1'b0;
      wb_sel     <= '0;
      wb_adr     <= '0;
      cnt        <= '0;
      tmo        <= '0;
      status_err <= 1'b0;
      tx_stb     <= 1'b0;
      tx_data    <= STALL_BYTE;
    end else begin
      if (latch_cmd) begin
        wb_we  <= rx_data[7];
        wb_sel <= rx_data[3:0];
      end
      if (latch_adr) wb_adr <= rx_data;
      cnt        <= cnt_d;
      tmo        <= tmo_d;
      status_err <= status_d;
      tx_stb     <= rx_stb;
      tx_data    <= rx_stb ? tx_data_d : STALL_BYTE;
    end
  end

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Directed bench for spi_wb_sequencer (TIMEOUT=16). Inputs change 1 ns after
// the rising edge; outputs are observed at that same point.
module tb_spi_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_start, rx_stb;
  logic [7:0]  rx_data;
  logic        tx_stb;
  logic [7:0]  tx_data;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_stall, wb_ack;

  int checks   = 0;
  int failures = 0;

  spi_wb_sequencer #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_start (rx_start),
    .rx_stb   (rx_stb),
    .rx_data  (rx_data),
    .tx_stb   (tx_stb),
    .tx_data  (tx_data),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_sel   (wb_sel),
    .wb_adr   (wb_adr),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_stall (wb_stall),
    .wb_ack   (wb_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One idle clk; no byte in, so no reply may appear.
  task automatic tick(input string tag);
    @(posedge clk); #1;
    check({tag, "_no_tx"}, {31'd0, tx_stb}, 32'd1 - 32'd1);
  endtask

  // Present one byte for one clk and check the reply that follows it.
  task automatic send(input logic [7:0] b, input logic [7:0] exp, input string tag);
    rx_stb = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_stb = 1'b0; rx_data = 8'h00;
    check({tag, "_tx_stb"}, {31'd0, tx_stb}, 32'd1);
    check({tag, "_tx_data"}, {24'd0, tx_data}, {24'd0, exp});
  endtask

  task automatic start_frame();
    rx_start = 1'b1;
    @(posedge clk); #1;
    rx_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_stb"}, {31'd0, tx_stb}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_cyc_stb_we"}, {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
    check({tag, "_sel"}, {28'd0, wb_sel}, 32'd0);
    check({tag, "_adr"}, {24'd0, wb_adr}, 32'd0);
    check({tag, "_dat_o"}, wb_dat_o, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rx_start = 1'b0; rx_stb = 1'b0; rx_data = 8'h00;
    wb_dat_i = 32'h0; wb_stall = 1'b0; wb_ack = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read, zero wait states: slave acks one clk after stb.
    send(8'h00, 8'h00, "rd_cmd");
    send(8'h10, 8'h00, "rd_adr");
    check("rd_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd3);
    check("rd_we_sel", {27'd0, wb_we, wb_sel}, 32'd0);
    check("rd_adr_out", {24'd0, wb_adr}, 32'h10);
    send(8'hA0, 8'h00, "rd_d1");
    check("rd_wait", {30'd0, wb_cyc, wb_stb}, 32'd2);
    wb_ack = 1'b1; wb_dat_i = 32'h12345678;
    @(posedge clk); #1;
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    check("rd_cyc_drop", {31'd0, wb_cyc}, 32'd0);
    send(8'hA1, 8'hFF, "rd_d2");
    send(8'hA2, 8'h12, "rd_d3");
    send(8'hA3, 8'h34, "rd_d4");
    send(8'hA4, 8'h56, "rd_d5");
    send(8'hA5, 8'h78, "rd_d6");
    send(8'hA6, 8'h00, "rd_done");

    // Write, ack taken in the same clk as the stb.
    start_frame();
    send(8'h8F, 8'h00, "wr_cmd");
    send(8'h20, 8'h00, "wr_adr");
    send(8'hDE, 8'h00, "wr_b0");
    send(8'hAD, 8'h00, "wr_b1");
    send(8'hBE, 8'h00, "wr_b2");
    send(8'hEF, 8'h00, "wr_b3");
    check("wr_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd3);
    check("wr_we_sel", {27'd0, wb_we, wb_sel}, 32'h1F);
    check("wr_adr_out", {24'd0, wb_adr}, 32'h20);
    check("wr_dat_o", wb_dat_o, 32'hDEADBEEF);
    wb_ack = 1'b1;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    check("wr_cyc_drop", {30'd0, wb_cyc, wb_stb}, 32'd0);
    send(8'h55, 8'hFF, "wr_status");
    send(8'h55, 8'h00, "wr_done");

    // Read with the slave stalling for 5 clk.
    start_frame();
    wb_stall = 1'b1;
    send(8'h03, 8'h00, "st_cmd");
    send(8'h44, 8'h00, "st_adr");
    for (int i = 0; i < 5; i++) begin
      check("st_stb_held", {23'd0, wb_stb, wb_adr}, {23'd0, 1'b1, 8'h44});
      @(posedge clk); #1;
    end
    wb_stall = 1'b0;
    check("st_stb_last", {31'd0, wb_stb}, 32'd1);
    tick("st_t1");
    check("st_stb_drop", {30'd0, wb_cyc, wb_stb}, 32'd2);
    tick("st_t2");
    check("st_cyc_held", {31'd0, wb_cyc}, 32'd1);
    wb_ack = 1'b1; wb_dat_i = 32'hCAFE0001;
    @(posedge clk); #1;
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    check("st_cyc_drop", {31'd0, wb_cyc}, 32'd0);
    send(8'h00, 8'hFF, "st_status");
    send(8'h00, 8'hCA, "st_data0");

    // Timeout: no ack ever arrives.
    start_frame();
    send(8'h00, 8'h00, "to_cmd");
    send(8'h55, 8'h00, "to_adr");
    n = 0;
    for (int i = 0; i < 40 && wb_cyc; i++) begin
      n++;
      @(posedge clk); #1;
    end
    check("to_cyc_cycles", n, 32'd16);
    send(8'h00, 8'hEE, "to_status");
    send(8'h00, 8'h00, "to_data0");
    send(8'h00, 8'h00, "to_data1");
    send(8'h00, 8'h00, "to_data2");
    send(8'h00, 8'h00, "to_data3");

    // Abort in WAIT, late ack, then a new frame starting with its CMD byte.
    start_frame();
    send(8'h00, 8'h00, "ab_cmd");
    send(8'h08, 8'h00, "ab_adr");
    tick("ab_t1");
    check("ab_wait", {30'd0, wb_cyc, wb_stb}, 32'd2);
    start_frame();
    check("ab_cyc_drop", {30'd0, wb_cyc, wb_stb}, 32'd0);
    wb_ack = 1'b1; wb_dat_i = 32'h99999999;
    tick("ab_late_ack");
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    check("ab_ignored", {30'd0, wb_cyc, wb_stb}, 32'd0);
    rx_start = 1'b1;
    send(8'h80, 8'h00, "ab_new_cmd");
    rx_start = 1'b0;
    send(8'h04, 8'h00, "ab_new_adr");
    check("ab_no_req_yet", {31'd0, wb_cyc}, 32'd0);
    send(8'h11, 8'h00, "ab_b0");
    send(8'h22, 8'h00, "ab_b1");
    send(8'h33, 8'h00, "ab_b2");
    send(8'h44, 8'h00, "ab_b3");
    check("ab_req", {22'd0, wb_cyc, wb_we, wb_sel, wb_adr}, {22'd0, 1'b1, 1'b1, 4'h0, 8'h04});
    check("ab_dat_o", wb_dat_o, 32'h11223344);
    wb_ack = 1'b1;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    send(8'h00, 8'hFF, "ab_status");

    // Asynchronous reset in the middle of WDATA.
    start_frame();
    send(8'h8F, 8'h00, "rs_cmd");
    send(8'h20, 8'h00, "rs_adr");
    send(8'hDE, 8'h00, "rs_b0");
    send(8'hAD, 8'h00, "rs_b1");
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("rs_async");
    rx_stb = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1;
    rx_stb = 1'b0; rx_data = 8'h00;
    check("rs_no_tx", {31'd0, tx_stb}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h00, 8'h00, "rs_cmd2");
    send(8'h30, 8'h00, "rs_adr2");
    check("rs_req", {22'd0, wb_cyc, wb_we, wb_sel, wb_adr}, {22'd0, 1'b1, 1'b0, 4'h0, 8'h30});
    wb_ack = 1'b1;
    tick("rs_ack");
    wb_ack = 1'b0;
    check("rs_cyc_drop", {31'd0, wb_cyc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
